// File: rtl/rx_frame_ingress.sv
// RX ingress: stores incoming frames into free packet-buffer slots and publishes
// (tag, length) descriptors to the dealer; drops on no-slot, overflow or force-stop.
module rx_frame_ingress #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned NUM_SLOTS       = 4,
    parameter int unsigned SLOT_ADDR_WIDTH = 11,
    parameter int unsigned TAG_WIDTH       = 8
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [DATA_WIDTH-1:0]                        rx_data,
    input  logic                                         rx_valid,
    input  logic                                         rx_last,
    output logic                                         rx_ready,
    input  logic                                         force_stop_rx,
    output logic                                         mem_wr_en,
    output logic [$clog2(NUM_SLOTS)+SLOT_ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0]                        mem_wr_data,
    output logic                                         frame_valid,
    input  logic                                         frame_ready,
    output logic [TAG_WIDTH-1:0]                         frame_tag,
    output logic [SLOT_ADDR_WIDTH:0]                     frame_len,
    input  logic                                         release_valid,
    input  logic [TAG_WIDTH-1:0]                         release_tag,
    output logic [$clog2(NUM_SLOTS):0]                   free_slots,
    output logic [15:0]                                  drop_count
);

    localparam int unsigned SW = $clog2(NUM_SLOTS);
    localparam int unsigned AW = SW + SLOT_ADDR_WIDTH;
    localparam int unsigned LW = SLOT_ADDR_WIDTH + 1;
    localparam int unsigned CW = SW + 1;

    typedef enum logic [1:0] {IDLE, RECV, DROP, PUBLISH} state_e;

    state_e                     state_q;
    logic [NUM_SLOTS-1:0]       busy_q;
    logic [NUM_SLOTS-1:0]       busy_d;
    logic [SW-1:0]              slot_q;
    logic [SLOT_ADDR_WIDTH-1:0] offset_q;
    logic                       rx_ready_q;
    logic                       wr_en_q;
    logic [AW-1:0]              wr_addr_q;
    logic [DATA_WIDTH-1:0]      wr_data_q;
    logic                       frame_valid_q;
    logic [TAG_WIDTH-1:0]       frame_tag_q;
    logic [LW-1:0]              frame_len_q;
    logic [CW-1:0]              free_q;
    logic [CW-1:0]              free_d;
    logic [15:0]                drop_q;

    logic          accept;
    logic          have_free;
    logic [SW-1:0] alloc_slot;
    logic [SW-1:0] rel_slot;
    logic          rel_held;
    logic          rel_ok;
    logic          claim;
    logic          no_slot_drop;
    logic          offset_full;
    logic          abort;

    assign accept       = rx_valid && rx_ready_q;
    assign offset_full  = (offset_q == {SLOT_ADDR_WIDTH{1'b1}});
    assign claim        = (state_q == IDLE) && accept && have_free;
    assign no_slot_drop = (state_q == IDLE) && accept && !have_free;
    // Force-stop wins over overflow and rx_last while a slot is being filled
    assign abort        = (state_q == RECV) && (force_stop_rx || (accept && offset_full));

    assign rel_slot = release_tag[SW-1:0];
    assign rel_held = ((state_q == RECV) || (state_q == PUBLISH)) && (slot_q == rel_slot);
    assign rel_ok   = release_valid
                   && ({1'b0, release_tag} < (TAG_WIDTH+1)'(NUM_SLOTS))
                   && busy_q[rel_slot]
                   && !rel_held;

    // Lowest-index free slot, taken from the pre-release busy vector
    always_comb begin
        have_free  = 1'b0;
        alloc_slot = '0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                have_free  = 1'b1;
                alloc_slot = SW'(i);
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (rel_ok) busy_d[rel_slot] = 1'b0;
        if (claim)  busy_d[alloc_slot] = 1'b1;
        if (abort)  busy_d[slot_q] = 1'b0;
        free_d = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            free_d = free_d + CW'(!busy_d[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            busy_q        <= '0;
            free_q        <= CW'(NUM_SLOTS);
            slot_q        <= '0;
            offset_q      <= '0;
            rx_ready_q    <= 1'b1;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_tag_q   <= '0;
            frame_len_q   <= '0;
            drop_q        <= '0;
        end else begin
            busy_q  <= busy_d;
            free_q  <= free_d;
            wr_en_q <= 1'b0;
            if ((no_slot_drop || abort) && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (have_free) begin
                            slot_q    <= alloc_slot;
                            offset_q  <= '0;
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= {alloc_slot, {SLOT_ADDR_WIDTH{1'b0}}};
                            wr_data_q <= rx_data;
                            if (rx_last) begin
                                state_q       <= PUBLISH;
                                rx_ready_q    <= 1'b0;
                                frame_valid_q <= 1'b1;
                                frame_tag_q   <= TAG_WIDTH'(alloc_slot);
                                frame_len_q   <= LW'(1);
                            end else begin
                                state_q <= RECV;
                            end
                        end else if (!rx_last) begin
                            state_q <= DROP;
                        end
                    end
                end
                RECV: begin
                    if (abort) begin
                        state_q <= (accept && rx_last) ? IDLE : DROP;
                    end else if (accept) begin
                        offset_q  <= offset_q + SLOT_ADDR_WIDTH'(1);
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= {slot_q, offset_q + SLOT_ADDR_WIDTH'(1)};
                        wr_data_q <= rx_data;
                        if (rx_last) begin
                            state_q       <= PUBLISH;
                            rx_ready_q    <= 1'b0;
                            frame_valid_q <= 1'b1;
                            frame_tag_q   <= TAG_WIDTH'(slot_q);
                            frame_len_q   <= LW'(offset_q) + LW'(2);
                        end
                    end
                end
                DROP: begin
                    if (accept && rx_last) state_q <= IDLE;
                end
                PUBLISH: begin
                    if (frame_ready) begin
                        state_q       <= IDLE;
                        rx_ready_q    <= 1'b1;
                        frame_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_ready    = rx_ready_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_tag   = frame_tag_q;
    assign frame_len   = frame_len_q;
    assign free_slots  = free_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_rx_frame_ingress.sv
// Scoreboard bench for rx_frame_ingress: a word-level slot/frame model predicts
// memory writes and published descriptors; a monitor checks them as they appear.
module tb_rx_frame_ingress;

    localparam int NS  = 4;
    localparam int SAW = 4;
    localparam int CAP = 16;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_last;
    logic        rx_ready;
    logic        force_stop_rx;
    logic        mem_wr_en;
    logic [5:0]  mem_wr_addr;
    logic [7:0]  mem_wr_data;
    logic        frame_valid;
    logic        frame_ready;
    logic [7:0]  frame_tag;
    logic [4:0]  frame_len;
    logic        release_valid;
    logic [7:0]  release_tag;
    logic [2:0]  free_slots;
    logic [15:0] drop_count;

    rx_frame_ingress #(
        .DATA_WIDTH(8), .NUM_SLOTS(NS), .SLOT_ADDR_WIDTH(SAW), .TAG_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(rx_ready),
        .force_stop_rx(force_stop_rx),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_tag(frame_tag), .frame_len(frame_len),
        .release_valid(release_valid), .release_tag(release_tag),
        .free_slots(free_slots), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int rmode = 0;   // 0 random frame_ready, 1 held low, 2 held high

    int wq[$];       // expected writes: {addr, data}
    int fq[$];       // expected frames: {tag, len}

    bit m_busy[NS];
    int m_mode;      // 0 between frames, 1 storing, 2 discarding
    int m_slot;
    int m_cnt;
    int m_drop;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail(string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s", name);
    endfunction

    function automatic int model_free();
        int n = 0;
        for (int i = 0; i < NS; i++) if (!m_busy[i]) n++;
        return n;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NS; i++) m_busy[i] = 1'b0;
        m_mode = 0; m_slot = 0; m_cnt = 0; m_drop = 0;
        wq.delete();
        fq.delete();
    endfunction

    function automatic void model_drop();
        if (m_drop < 65535) m_drop++;
    endfunction

    // Frame-level rules applied to each accepted word
    function automatic void model_word(int d, bit last, bit fs);
        int s;
        case (m_mode)
            0: begin
                s = -1;
                for (int i = NS - 1; i >= 0; i--) if (!m_busy[i]) s = i;
                if (s < 0) begin
                    model_drop();
                    m_mode = last ? 0 : 2;
                end else begin
                    m_busy[s] = 1'b1;
                    m_slot = s;
                    wq.push_back(((s * CAP) << 8) | d);
                    m_cnt = 1;
                    if (last) fq.push_back((s << 8) | 1);
                    m_mode = last ? 0 : 1;
                end
            end
            1: begin
                if (fs || m_cnt == CAP) begin
                    m_busy[m_slot] = 1'b0;
                    model_drop();
                    m_mode = last ? 0 : 2;
                end else begin
                    wq.push_back(((m_slot * CAP + m_cnt) << 8) | d);
                    m_cnt++;
                    if (last) begin
                        fq.push_back((m_slot << 8) | m_cnt);
                        m_mode = 0;
                    end
                end
            end
            default: if (last) m_mode = 0;
        endcase
    endfunction

    task automatic send_word(input logic [7:0] d, input bit last, input bit fs);
        int  n = 0;
        logic acc;
        rx_valid = 1'b1; rx_data = d; rx_last = last; force_stop_rx = fs;
        do begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 200);
        rx_valid = 1'b0; rx_last = 1'b0; force_stop_rx = 1'b0;
        if (!acc) fail("rx_accept_timeout");
        else model_word(int'(d), last, fs);
    endtask

    task automatic do_release(input int tag);
        release_valid = 1'b1;
        release_tag = 8'(tag);
        @(posedge clk); #1;
        release_valid = 1'b0;
        if (tag < NS && m_busy[tag] && !(m_mode == 1 && m_slot == tag)) m_busy[tag] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!rx_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rx_ready) fail("publish_timeout");
        @(posedge clk); #1;
        chk("free_slots", 32'(free_slots), 32'(model_free()));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
    endtask

    task automatic send_frame(input int len, input int fs_at, input int base, input int rel_pct);
        for (int i = 0; i < len; i++) begin
            logic [7:0] d;
            d = (base >= 0) ? 8'(base + i) : 8'($urandom_range(0, 255));
            send_word(d, (i == len - 1), (i == fs_at));
            if (i != len - 1) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
                if (int'($urandom_range(0, 99)) < rel_pct) do_release(int'($urandom_range(0, 5)));
            end
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_mem_wr_en",   32'(mem_wr_en), 32'(0));
        chk("rst_mem_wr_addr", 32'(mem_wr_addr), 32'(0));
        chk("rst_mem_wr_data", 32'(mem_wr_data), 32'(0));
        chk("rst_frame_valid", 32'(frame_valid), 32'(0));
        chk("rst_frame_tag",   32'(frame_tag), 32'(0));
        chk("rst_frame_len",   32'(frame_len), 32'(0));
        chk("rst_drop_count",  32'(drop_count), 32'(0));
        chk("rst_free_slots",  32'(free_slots), 32'(NS));
        chk("rst_rx_ready",    32'(rx_ready), 32'(1));
    endtask

    // frame_ready driver
    initial begin
        frame_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                1:       frame_ready = 1'b0;
                2:       frame_ready = 1'b1;
                default: frame_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops and compares whenever the DUT presents a write or a frame
    initial begin
        int   e;
        logic prev_hold;
        logic prev_hs;
        logic [7:0] ptag;
        logic [4:0] plen;
        prev_hold = 1'b0; prev_hs = 1'b0; ptag = '0; plen = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_hold = 1'b0;
                prev_hs = 1'b0;
            end else begin
                if (mem_wr_en) begin
                    if (wq.size() == 0) begin
                        fail("unexpected_mem_write");
                    end else begin
                        e = wq.pop_front();
                        chk("mem_wr_addr", 32'(mem_wr_addr), 32'((e >> 8) & 8'h3F));
                        chk("mem_wr_data", 32'(mem_wr_data), 32'(e & 8'hFF));
                    end
                end
                if (prev_hs) chk("rx_ready_after_accept", 32'(rx_ready), 32'(1));
                if (prev_hold) begin
                    chk("frame_valid_hold", 32'(frame_valid), 32'(1));
                    chk("frame_tag_hold", 32'(frame_tag), 32'(ptag));
                    chk("frame_len_hold", 32'(frame_len), 32'(plen));
                end
                if (frame_valid) chk("rx_ready_in_publish", 32'(rx_ready), 32'(0));
                if (frame_valid && frame_ready) begin
                    if (fq.size() == 0) begin
                        fail("unexpected_frame");
                    end else begin
                        e = fq.pop_front();
                        chk("frame_tag", 32'(frame_tag), 32'(e >> 8));
                        chk("frame_len", 32'(frame_len), 32'(e & 8'hFF));
                    end
                end
                prev_hold = frame_valid && !frame_ready;
                prev_hs   = frame_valid && frame_ready;
                ptag = frame_tag;
                plen = frame_len;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        rx_data = '0; rx_valid = 1'b0; rx_last = 1'b0; force_stop_rx = 1'b0;
        release_valid = 1'b0; release_tag = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;
        @(posedge clk); #1;

        // 5-word frame into slot 0
        send_frame(5, -1, 8'h11, 0);
        wait_idle();
        do_release(0);

        // Fill every slot, then a frame with nowhere to go; then reuse a freed slot
        for (int k = 0; k < NS; k++) begin
            send_frame(1, -1, 8'h20 + k, 0);
        end
        send_frame(3, -1, 8'h30, 0);
        wait_idle();
        do_release(2);
        send_frame(1, -1, 8'h38, 0);
        wait_idle();
        for (int k = 0; k < NS; k++) do_release(k);
        wait_idle();

        // Overflow: one word more than a slot holds
        send_frame(CAP + 1, -1, 8'h40, 0);
        wait_idle();

        // Force-stop on the third word, then the slot is reused
        send_frame(10, 2, 8'h80, 0);
        wait_idle();
        send_frame(2, -1, 8'h90, 0);
        wait_idle();
        do_release(0);
        wait_idle();

        // Dealer stalls for several cycles in PUBLISH
        rmode = 1;
        repeat (2) @(posedge clk);
        #1;
        send_frame(1, -1, 8'hA0, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("stall_frame_valid", 32'(frame_valid), 32'(1));
        chk("stall_rx_ready", 32'(rx_ready), 32'(0));
        rmode = 2;
        wait_idle();
        rmode = 0;

        // Reset in the middle of a 6-word frame
        for (int i = 0; i < 3; i++) send_word(8'(8'hB0 + i), 1'b0, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_frame_valid", 32'(frame_valid), 32'(0));
        chk("post_reset_free_slots", 32'(free_slots), 32'(NS));

        // Randomized traffic with releases, force-stops and stalls
        for (int k = 0; k < 80; k++) begin
            int len;
            int fs_at;
            len = int'($urandom_range(1, CAP + 4));
            fs_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            send_frame(len, fs_at, -1, 15);
            if ($urandom_range(0, 2) == 0) begin
                wait_idle();
                if ($urandom_range(0, 1) == 0) do_release(int'($urandom_range(0, 5)));
            end
        end
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("writes_outstanding", 32'(wq.size()), 32'(0));
        chk("frames_outstanding", 32'(fq.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
